regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Shares one regfile write port between the pipeline (P, fixed priority) and a buffered multicycle unit (M).
// M results wait in a 1-entry holding buffer; a starved result eventually requests a pipeline bubble.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_valid,
  input  logic [4:0]  p_addr,
  input  logic [31:0] p_data,
  input  logic        m_valid,
  input  logic [4:0]  m_addr,
  input  logic [31:0] m_data,
  output logic        m_ready,
  output logic        stall_req,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic        write_enable
);

  typedef enum logic [1:0] {IDLE, HOLD, FORCE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  hold_addr_q, hold_addr_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        m_ready_q, m_ready_d;
  logic        stall_req_q, stall_req_d;

  logic       p_eff;
  logic       buf_full;
  logic       buf_wr;
  logic       waw_hit;
  logic [3:0] cnt_inc;

  always_comb begin
    p_eff    = p_valid && (p_addr != 5'd0);
    buf_full = (state_q != IDLE);
    // A held result is never written while reset is asserted.
    buf_wr   = buf_full && !p_eff && !reset;
    waw_hit  = buf_full && p_eff && (p_addr == hold_addr_q);
    cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    state_d     = state_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        // An accept targeting r0 is consumed without filling the buffer.
        if (m_valid && m_ready_q && (m_addr != 5'd0)) begin
          state_d     = HOLD;
          hold_addr_d = m_addr;
          hold_data_d = m_data;
          cnt_d       = 4'd0;
        end
      end
      HOLD, FORCE: begin
        // Either the buffer drains, or P overwrote the same register and the held value is stale.
        if (!p_eff || waw_hit) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_inc;
          if ((state_q == HOLD) && (cnt_inc >= 4'(STARVE_LIMIT)))
            state_d = FORCE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    m_ready_d   = (state_d == IDLE);
    stall_req_d = (state_d == FORCE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_addr_q <= 5'd0;
      hold_data_q <= 32'd0;
      cnt_q       <= 4'd0;
      m_ready_q   <= 1'b1;
      stall_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      cnt_q       <= cnt_d;
      m_ready_q   <= m_ready_d;
      stall_req_q <= stall_req_d;
    end
  end

  always_comb begin
    write_enable = 1'b0;
    wa3          = 5'd0;
    wd3          = 32'd0;
    if (p_eff) begin
      write_enable = 1'b1;
      wa3          = p_addr;
      wd3          = p_data;
    end else if (buf_wr) begin
      write_enable = 1'b1;
      wa3          = hold_addr_q;
      wd3          = hold_data_q;
    end
  end

  assign m_ready   = m_ready_q;
  assign stall_req = stall_req_q;

endmodule
